multi_channel_clock_divider: RTL and testbench

MULTI_CHANNEL_CLOCK_DIVIDER -- requirements
Module: multi_channel_clock_divider

---
 rtl/clk_div_pkg.sv | 23 ++
 rtl/clock_divider_channel.sv | 99 +++++++++
 rtl/multi_channel_clock_divider.sv | 46 ++++
 tb/tb_multi_channel_clock_divider.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and per-channel configuration type for the multi-channel clock divider.
// Config fields are CFG_W wide so any divider width N <= CFG_W can store its (period, low) pair.
package clk_div_pkg;

  localparam int unsigned DEF_N      = 20;
  localparam int unsigned DEF_CH     = 4;
  localparam int unsigned DEF_PERIOD = 1000;
  localparam int unsigned CFG_W      = 32;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] low;
  } ch_cfg_t;

  function automatic ch_cfg_t make_cfg(input logic [CFG_W-1:0] period,
                                       input logic [CFG_W-1:0] low);
    ch_cfg_t cfg;
    cfg.period = period;
    cfg.low    = low;
    return cfg;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active and staged (period, low) pairs, registered out_clk/tick/pending.
// Staged values are only swapped in when the counter restarts, so the waveform never glitches.
module clock_divider_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned N              = DEF_N,
  parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD
) (
  input  logic         in_clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         sync_restart_i,
  input  logic         wr_i,
  input  logic [N-1:0] wr_period_i,
  input  logic [N-1:0] wr_low_i,
  output logic         out_clk_o,
  output logic         tick_o,
  output logic         pending_o
);

  localparam ch_cfg_t RST_CFG = make_cfg(CFG_W'(DEFAULT_PERIOD), CFG_W'(DEFAULT_PERIOD / 32'd2));

  logic [N-1:0]     cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  ch_cfg_t          act_q, act_d;
  ch_cfg_t          stg_q, stg_d;
  logic [CFG_W-1:0] cnt_ext_s;
  logic             idle_s;
  logic             wrap_s;
  logic             apply_s;

  assign cnt_ext_s = CFG_W'(cnt_q);
  assign idle_s    = (act_q.period < 32'd2);
  assign wrap_s    = (cnt_ext_s == (act_q.period - 32'd1));

  // Next-state: hold-at-zero cases (off, restart, idle) share one path and all allow a config swap.
  always_comb begin
    cnt_d   = cnt_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    act_d   = act_q;
    stg_d   = stg_q;
    pend_d  = pend_q;
    apply_s = 1'b0;
    if (!en_i || sync_restart_i || idle_s) begin
      cnt_d   = '0;
      out_d   = 1'b0;
      apply_s = 1'b1;
    end else begin
      if (wrap_s) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        apply_s = 1'b1;
      end else begin
        cnt_d   = cnt_q + N'(1);
      end
      out_d = (cnt_ext_s >= act_q.low);
    end
    if (apply_s && pend_q) begin
      act_d  = stg_q;
      pend_d = 1'b0;
    end else begin
      act_d  = act_q;
    end
    // A write on the swap edge stages behind the pair being activated and keeps pending set.
    if (wr_i) begin
      stg_d  = make_cfg(CFG_W'(wr_period_i), CFG_W'(wr_low_i));
      pend_d = 1'b1;
    end else begin
      stg_d  = stg_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge in_clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
      act_q  <= RST_CFG;
      stg_q  <= RST_CFG;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      stg_q  <= stg_d;
    end
  end

  assign out_clk_o = out_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// CH independent programmable clock dividers sharing one configuration write port.
// The top only decodes cfg_ch; all state lives in the channel instances.
module multi_channel_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned N              = DEF_N,
  parameter int unsigned CH             = DEF_CH,
  parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD
) (
  input  logic                                                in_clk,
  input  logic                                                reset,
  input  logic [CH-1:0]                                       on_off,
  input  logic                                                sync_restart,
  input  logic                                                cfg_valid,
  input  logic [((CH > 32'd1) ? $clog2(CH) : 32'd1)-32'd1:0]  cfg_ch,
  input  logic [N-1:0]                                        cfg_period,
  input  logic [N-1:0]                                        cfg_low,
  output logic [CH-1:0]                                       out_clk,
  output logic [CH-1:0]                                       tick,
  output logic [CH-1:0]                                       cfg_pending
);

  logic [CH-1:0] wr_s;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    // Out-of-range channel numbers match no instance and are dropped.
    assign wr_s[g] = cfg_valid && (int'(cfg_ch) == g);

    clock_divider_channel #(
      .N              (N),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .in_clk_i       (in_clk),
      .reset_i        (reset),
      .en_i           (on_off[g]),
      .sync_restart_i (sync_restart),
      .wr_i           (wr_s[g]),
      .wr_period_i    (cfg_period),
      .wr_low_i       (cfg_low),
      .out_clk_o      (out_clk[g]),
      .tick_o         (tick[g]),
      .pending_o      (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench: a vector table for the ch1 reconfiguration waveform plus hand-written sequences
// for default period, L boundaries, write-on-wrap, sync restart and mid-period reset.
module tb_multi_channel_clock_divider;

  logic        in_clk = 1'b0;
  logic        reset;
  logic [3:0]  on_off;
  logic        sync_restart;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [19:0] cfg_period;
  logic [19:0] cfg_low;
  logic [3:0]  out_clk;
  logic [3:0]  tick;
  logic [3:0]  cfg_pending;

  int n_checks = 0;
  int n_fail   = 0;

  multi_channel_clock_divider #(.N(20), .CH(4), .DEFAULT_PERIOD(1000)) dut (
    .in_clk       (in_clk),
    .reset        (reset),
    .on_off       (on_off),
    .sync_restart (sync_restart),
    .cfg_valid    (cfg_valid),
    .cfg_ch       (cfg_ch),
    .cfg_period   (cfg_period),
    .cfg_low      (cfg_low),
    .out_clk      (out_clk),
    .tick         (tick),
    .cfg_pending  (cfg_pending)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [3:0]  on;
    logic        wr;
    logic [19:0] p;
    logic [19:0] l;
    logic [3:0]  e_out;
    logic [3:0]  e_tick;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [3:0] on, input logic wr, input logic [19:0] p,
                              input logic [19:0] l, input logic [3:0] eo, input logic [3:0] et,
                              input logic [3:0] ep);
    vec_t v;
    v.on = on; v.wr = wr; v.p = p; v.l = l;
    v.e_out = eo; v.e_tick = et; v.e_pend = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] on, input logic sr, input logic v, input logic [1:0] ch,
                       input logic [19:0] p, input logic [19:0] l);
    on_off = on; sync_restart = sr; cfg_valid = v; cfg_ch = ch; cfg_period = p; cfg_low = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if (tick[ch] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int first_rise, first_fall, t1, t2, nt, bad, n, f0, f1, fb;
    logic prev;

    vecs[0]  = mk(4'b0000, 1'b1, 20'd10, 20'd3, 4'b0000, 4'b0000, 4'b0010);
    vecs[1]  = mk(4'b0000, 1'b0, 20'd0,  20'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[2]  = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[3]  = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[4]  = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[5]  = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0000);
    vecs[6]  = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0000);
    vecs[7]  = mk(4'b0010, 1'b1, 20'd4,  20'd1, 4'b0010, 4'b0000, 4'b0010);
    vecs[8]  = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0010);
    vecs[9]  = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0010);
    vecs[10] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0010);
    vecs[11] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0010, 4'b0000);
    vecs[12] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[13] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0000);
    vecs[14] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0000);
    vecs[15] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0010, 4'b0000);
    vecs[16] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0000, 4'b0000, 4'b0000);
    vecs[17] = mk(4'b0010, 1'b0, 20'd0,  20'd0, 4'b0010, 4'b0000, 4'b0000);

    // Reset state
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    #1;
    check("reset out_clk", 32'(out_clk), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset cfg_pending", 32'(cfg_pending), 32'd0);

    // Default period on ch0: low 500, high 500, tick every 1000
    do_reset();
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    first_rise = -1; first_fall = -1; t1 = -1; t2 = -1; nt = 0; prev = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      step();
      if (out_clk[0] && !prev && first_rise < 0) first_rise = k;
      if (!out_clk[0] && prev && first_fall < 0) first_fall = k;
      if (tick[0]) begin
        nt++;
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
      prev = out_clk[0];
    end
    check("s1 first rise", 32'(first_rise), 32'd501);
    check("s1 first fall", 32'(first_fall), 32'd1001);
    check("s1 tick count", 32'(nt), 32'd2);
    check("s1 tick1 cycle", 32'(t1), 32'd1000);
    check("s1 tick2 cycle", 32'(t2), 32'd2000);

    // ch1 P=10 L=3 with mid-period rewrite to P=4 L=1
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].on, 1'b0, vecs[i].wr, 2'd1, vecs[i].p, vecs[i].l);
      step();
      check($sformatf("s2 row%0d out_clk", i), 32'(out_clk), 32'(vecs[i].e_out));
      check($sformatf("s2 row%0d tick", i), 32'(tick), 32'(vecs[i].e_tick));
      check($sformatf("s2 row%0d cfg_pending", i), 32'(cfg_pending), 32'(vecs[i].e_pend));
    end

    // ch2 boundaries: L=0 constant high, L=P constant low, P=1 idle
    do_reset();
    drive(4'b0000, 1'b0, 1'b1, 2'd2, 20'd12, 20'd0); step();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);  step();
    drive(4'b0100, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    bad = 0; nt = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (out_clk[2] !== 1'b1) bad++;
      if (tick[2]) nt++;
    end
    check("s3 L=0 not high cycles", 32'(bad), 32'd0);
    check("s3 L=0 ticks", 32'(nt), 32'd2);
    drive(4'b0000, 1'b0, 1'b1, 2'd2, 20'd12, 20'd12); step();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);   step();
    drive(4'b0100, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    bad = 0; nt = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (out_clk[2] !== 1'b0) bad++;
      if (tick[2]) nt++;
    end
    check("s3 L=P not low cycles", 32'(bad), 32'd0);
    check("s3 L=P ticks", 32'(nt), 32'd2);
    drive(4'b0000, 1'b0, 1'b1, 2'd2, 20'd1, 20'd0); step();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0); step();
    drive(4'b0100, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    bad = 0; nt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_clk[2] !== 1'b0) bad++;
      if (tick[2]) nt++;
    end
    check("s3 P=1 not low cycles", 32'(bad), 32'd0);
    check("s3 P=1 ticks", 32'(nt), 32'd0);

    // Write coincident with wrap on ch0
    do_reset();
    drive(4'b0000, 1'b0, 1'b1, 2'd0, 20'd5, 20'd2); step();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0); step();
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0); step(); step();
    drive(4'b0001, 1'b0, 1'b1, 2'd0, 20'd6, 20'd3); step();
    check("s4 pending after first write", 32'(cfg_pending[0]), 32'd1);
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0); step();
    drive(4'b0001, 1'b0, 1'b1, 2'd0, 20'd8, 20'd4); step();
    check("s4 tick at wrap", 32'(tick[0]), 32'd1);
    check("s4 pending stays on wrap write", 32'(cfg_pending[0]), 32'd1);
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    wait_tick(0, 50, n);
    check("s4 period after wrap (6)", 32'(n), 32'd6);
    check("s4 pending cleared", 32'(cfg_pending[0]), 32'd0);
    wait_tick(0, 50, n);
    check("s4 next period (8)", 32'(n), 32'd8);

    // sync_restart on P=6 and P=9, coinciding with a ch0 wrap
    do_reset();
    drive(4'b0000, 1'b0, 1'b1, 2'd0, 20'd6, 20'd3); step();
    drive(4'b0000, 1'b0, 1'b1, 2'd1, 20'd9, 20'd4); step();
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0); step();
    drive(4'b0011, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    repeat (5) step();
    check("s5 ch1 high before restart", 32'(out_clk[1]), 32'd1);
    drive(4'b0011, 1'b1, 1'b0, 2'd0, 20'd0, 20'd0); step();
    check("s5 restart out_clk", 32'(out_clk[1:0]), 32'd0);
    check("s5 restart no tick", 32'(tick[1:0]), 32'd0);
    drive(4'b0011, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    f0 = -1; f1 = -1; fb = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tick[0] && f0 < 0) f0 = k;
      if (tick[1] && f1 < 0) f1 = k;
      if (tick[0] && tick[1] && fb < 0) fb = k;
    end
    check("s5 ch0 first tick", 32'(f0), 32'd6);
    check("s5 ch1 first tick", 32'(f1), 32'd9);
    check("s5 aligned tick", 32'(fb), 32'd18);

    // Reset mid-period with a pending write on ch0
    do_reset();
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    repeat (600) step();
    check("s6 high before reset", 32'(out_clk[0]), 32'd1);
    drive(4'b0001, 1'b0, 1'b1, 2'd0, 20'd4, 20'd2); step();
    check("s6 pending before reset", 32'(cfg_pending[0]), 32'd1);
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
    #3 reset = 1'b1;
    #1;
    check("s6 async out_clk", 32'(out_clk), 32'd0);
    check("s6 async cfg_pending", 32'(cfg_pending), 32'd0);
    step();
    reset = 1'b0;
    first_rise = -1;
    for (int k = 1; k <= 700; k++) begin
      step();
      if (out_clk[0] && first_rise < 0) first_rise = k;
    end
    check("s6 default restored rise", 32'(first_rise), 32'd501);
    check("s6 pending after release", 32'(cfg_pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
